multi_ctrl: RTL and testbench

Multicycle control unit for the MIPS-subset CPU: a Moore-style FSM that sequences the shared ALU, memory port, register file and immediate extender across 3–5 cycles per instruction. It sits beside the datapath, takes opcode/funct from the instruction register and the ALU zero flag, and drives every datapath enable and mux select. It also selects the immediate-extension mode: sign-extend or zero-extend.

---
 rtl/multi_ctrl_pkg.sv | 65 ++++++
 rtl/multi_ctrl_alu_dec.sv | 51 +++++
 rtl/multi_ctrl.sv | 179 +++++++++++++++++
 tb/tb_multi_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit.
package multi_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_MADR = 4'd2,
        S_MRD  = 4'd3,
        S_MWB  = 4'd4,
        S_MWR  = 4'd5,
        S_REX  = 4'd6,
        S_RWB  = 4'd7,
        S_BEQ  = 4'd8,
        S_JMP  = 4'd9,
        S_IEX  = 4'd10,
        S_IWB  = 4'd11
    } state_e;

    // ALU control class a state asks the decoder for
    typedef enum logic [2:0] {
        ACLS_NONE = 3'd0,
        ACLS_ADD  = 3'd1,
        ACLS_SUB  = 3'd2,
        ACLS_FUNC = 3'd3,
        ACLS_IMM  = 3'd4
    } alu_cls_e;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic is_known_op(input logic [5:0] op);
        case (op)
            OP_R, OP_J, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW: is_known_op = 1'b1;
            default:                                                    is_known_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multi_ctrl_alu_dec.sv
// ALU function and extender-mode decode, shared by the R-type and immediate execute states.
module multi_ctrl_alu_dec
    import multi_ctrl_pkg::*;
(
    input  alu_cls_e    i_cls,
    input  logic [5:0]  i_opcode,
    input  logic [5:0]  i_funct,
    output logic [2:0]  o_alu_op_c,
    output logic        o_ext_op_c,
    output logic        o_bad_funct_c
);

    always_comb begin
        o_alu_op_c    = ALU_AND;
        o_ext_op_c    = 1'b1;
        o_bad_funct_c = 1'b0;
        case (i_cls)
            ACLS_ADD: o_alu_op_c = ALU_ADD;
            ACLS_SUB: o_alu_op_c = ALU_SUB;
            ACLS_FUNC: begin
                case (i_funct)
                    FN_ADD:  o_alu_op_c = ALU_ADD;
                    FN_SUB:  o_alu_op_c = ALU_SUB;
                    FN_AND:  o_alu_op_c = ALU_AND;
                    FN_OR:   o_alu_op_c = ALU_OR;
                    FN_SLT:  o_alu_op_c = ALU_SLT;
                    default: begin
                        o_alu_op_c    = ALU_ADD;
                        o_bad_funct_c = 1'b1;
                    end
                endcase
            end
            // logical immediates are zero-extended, addi is sign-extended
            ACLS_IMM: begin
                case (i_opcode)
                    OP_ANDI: begin
                        o_alu_op_c = ALU_AND;
                        o_ext_op_c = 1'b0;
                    end
                    OP_ORI: begin
                        o_alu_op_c = ALU_OR;
                        o_ext_op_c = 1'b0;
                    end
                    default: o_alu_op_c = ALU_ADD;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multi_ctrl.sv
// Multicycle control FSM: sequences ALU, memory, register file and extender per instruction.
module multi_ctrl
    import multi_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pc_wr,
    output logic             iord,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             ir_wr,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_wr,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             ext_op,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    state_e           r_state;
    state_e           w_next;
    alu_cls_e         w_cls;
    logic [2:0]       w_alu_op;
    logic             w_ext_op;
    logic             w_bad_funct;
    logic             w_bad_op;
    logic             w_retire;
    logic             w_pc_wr;
    logic             w_mem_rd;
    logic             w_mem_wr;
    logic             w_ir_wr;
    logic             w_reg_wr;
    logic             r_illegal;
    logic [CNT_W-1:0] r_instr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IF;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = S_IF;
        case (r_state)
            S_IF: w_next = S_ID;
            S_ID: begin
                case (opcode)
                    OP_LW, OP_SW:             w_next = S_MADR;
                    OP_R:                     w_next = S_REX;
                    OP_BEQ:                   w_next = S_BEQ;
                    OP_J:                     w_next = S_JMP;
                    OP_ADDI, OP_ANDI, OP_ORI: w_next = S_IEX;
                    default:                  w_next = S_IF;
                endcase
            end
            S_MADR:  w_next = (opcode == OP_LW) ? S_MRD : S_MWR;
            S_MRD:   w_next = S_MWB;
            S_REX:   w_next = S_RWB;
            S_IEX:   w_next = S_IWB;
            default: w_next = S_IF;
        endcase
    end

    always_comb begin
        w_cls = ACLS_NONE;
        case (r_state)
            S_IF, S_ID, S_MADR: w_cls = ACLS_ADD;
            S_BEQ:              w_cls = ACLS_SUB;
            S_REX:              w_cls = ACLS_FUNC;
            S_IEX:              w_cls = ACLS_IMM;
            default:            w_cls = ACLS_NONE;
        endcase
    end

    multi_ctrl_alu_dec u_alu_dec (
        .i_cls         (w_cls),
        .i_opcode      (opcode),
        .i_funct       (funct),
        .o_alu_op_c    (w_alu_op),
        .o_ext_op_c    (w_ext_op),
        .o_bad_funct_c (w_bad_funct)
    );

    always_comb begin
        w_pc_wr    = 1'b0;
        iord       = 1'b0;
        w_mem_rd   = 1'b0;
        w_mem_wr   = 1'b0;
        w_ir_wr    = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        w_reg_wr   = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        pc_src     = PCSRC_ALU;
        alu_op     = w_alu_op;
        ext_op     = w_ext_op;
        case (r_state)
            S_IF: begin
                w_mem_rd  = 1'b1;
                w_ir_wr   = 1'b1;
                alu_src_b = SRCB_FOUR;
                w_pc_wr   = 1'b1;
            end
            S_ID:   alu_src_b = SRCB_IMM_SH;
            S_MADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MRD: begin
                w_mem_rd = 1'b1;
                iord     = 1'b1;
            end
            S_MWB: begin
                w_reg_wr   = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MWR: begin
                w_mem_wr = 1'b1;
                iord     = 1'b1;
            end
            S_REX:  alu_src_a = 1'b1;
            S_RWB: begin
                w_reg_wr = 1'b1;
                reg_dst  = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 1'b1;
                pc_src    = PCSRC_ALUOUT;
                w_pc_wr   = zero;
            end
            S_JMP: begin
                pc_src  = PCSRC_JUMP;
                w_pc_wr = 1'b1;
            end
            S_IEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_IWB:  w_reg_wr = 1'b1;
            default: ;
        endcase
    end

    // write enables held off for the whole time reset is asserted
    assign pc_wr  = rst_n & w_pc_wr;
    assign mem_rd = rst_n & w_mem_rd;
    assign mem_wr = rst_n & w_mem_wr;
    assign ir_wr  = rst_n & w_ir_wr;
    assign reg_wr = rst_n & w_reg_wr;

    assign w_bad_op = (r_state == S_ID) && !is_known_op(opcode);
    assign w_retire = (r_state == S_MWB) || (r_state == S_MWR) || (r_state == S_RWB) ||
                      (r_state == S_BEQ) || (r_state == S_JMP) || (r_state == S_IWB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal   <= 1'b0;
            r_instr_cnt <= '0;
        end else begin
            if (w_bad_op || ((r_state == S_REX) && w_bad_funct)) r_illegal <= 1'b1;
            if (w_retire) r_instr_cnt <= r_instr_cnt + CNT_W'(1);
        end
    end

    assign illegal   = r_illegal;
    assign instr_cnt = r_instr_cnt;
    assign state     = r_state;

endmodule

// File: tb/tb_multi_ctrl.sv
// Directed bench for multi_ctrl: walks each instruction class through its states.
module tb_multi_ctrl;

    localparam int unsigned CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             pc_wr, iord, mem_rd, mem_wr, ir_wr, reg_dst, mem_to_reg, reg_wr;
    logic             alu_src_a, ext_op, illegal;
    logic [1:0]       alu_src_b, pc_src;
    logic [2:0]       alu_op;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    multi_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .pc_wr      (pc_wr),
        .iord       (iord),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .ir_wr      (ir_wr),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_wr     (reg_wr),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .ext_op     (ext_op),
        .illegal    (illegal),
        .state      (state),
        .instr_cnt  (instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n  = 1'b0;
        opcode = 6'h00;
        funct  = 6'h00;
        zero   = 1'b0;
        repeat (2) tick();

        // reset: IF values with write enables forced low
        check("rst_state", 32'(state), 32'd0);
        check("rst_pc_wr", 32'(pc_wr), 32'd0);
        check("rst_ir_wr", 32'(ir_wr), 32'd0);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_srcb", 32'(alu_src_b), 32'd1);
        check("rst_aluop", 32'(alu_op), 32'd2);
        check("rst_cnt", instr_cnt, 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);

        // sw: 0 -> 1 -> 2 -> 5 -> 0
        opcode = 6'h2B;
        rst_n  = 1'b1;
        #1;
        check("if_pc_wr", 32'(pc_wr), 32'd1);
        check("if_ir_wr", 32'(ir_wr), 32'd1);
        check("if_mem_rd", 32'(mem_rd), 32'd1);
        tick();
        check("sw_id_state", 32'(state), 32'd1);
        check("sw_id_srcb", 32'(alu_src_b), 32'd3);
        check("sw_id_pc_wr", 32'(pc_wr), 32'd0);
        tick();
        check("sw_madr_state", 32'(state), 32'd2);
        check("sw_madr_srca", 32'(alu_src_a), 32'd1);
        check("sw_madr_srcb", 32'(alu_src_b), 32'd2);
        check("sw_madr_mem_wr", 32'(mem_wr), 32'd0);
        tick();
        check("sw_mwr_state", 32'(state), 32'd5);
        check("sw_mwr_mem_wr", 32'(mem_wr), 32'd1);
        check("sw_mwr_iord", 32'(iord), 32'd1);
        tick();
        check("sw_done_state", 32'(state), 32'd0);
        check("sw_done_mem_wr", 32'(mem_wr), 32'd0);
        check("sw_cnt", instr_cnt, 32'd1);

        // lw: 0 -> 1 -> 2 -> 3 -> 4 -> 0
        opcode = 6'h23;
        tick();
        check("lw_id_state", 32'(state), 32'd1);
        tick();
        check("lw_madr_state", 32'(state), 32'd2);
        tick();
        check("lw_mrd_state", 32'(state), 32'd3);
        check("lw_mrd_mem_rd", 32'(mem_rd), 32'd1);
        check("lw_mrd_iord", 32'(iord), 32'd1);
        tick();
        check("lw_mwb_state", 32'(state), 32'd4);
        check("lw_mwb_reg_wr", 32'(reg_wr), 32'd1);
        check("lw_mwb_m2r", 32'(mem_to_reg), 32'd1);
        check("lw_mwb_regdst", 32'(reg_dst), 32'd0);
        tick();
        check("lw_done_state", 32'(state), 32'd0);
        check("lw_cnt", instr_cnt, 32'd2);

        // add: 0 -> 1 -> 6 -> 7 -> 0
        opcode = 6'h00;
        funct  = 6'h20;
        tick();
        tick();
        check("add_rex_state", 32'(state), 32'd6);
        check("add_rex_aluop", 32'(alu_op), 32'd2);
        check("add_rex_srcb", 32'(alu_src_b), 32'd0);
        check("add_rex_srca", 32'(alu_src_a), 32'd1);
        tick();
        check("add_rwb_state", 32'(state), 32'd7);
        check("add_rwb_reg_wr", 32'(reg_wr), 32'd1);
        check("add_rwb_regdst", 32'(reg_dst), 32'd1);
        check("add_rwb_m2r", 32'(mem_to_reg), 32'd0);
        tick();
        check("add_cnt", instr_cnt, 32'd3);

        // slt decodes to 111 in REX
        funct = 6'h2A;
        tick();
        tick();
        check("slt_rex_aluop", 32'(alu_op), 32'd7);
        tick();
        tick();
        check("slt_cnt", instr_cnt, 32'd4);

        // beq taken then not taken
        opcode = 6'h04;
        zero   = 1'b1;
        tick();
        tick();
        check("beq1_state", 32'(state), 32'd8);
        check("beq1_pc_wr", 32'(pc_wr), 32'd1);
        check("beq1_pc_src", 32'(pc_src), 32'd1);
        check("beq1_aluop", 32'(alu_op), 32'd6);
        tick();
        check("beq1_done_state", 32'(state), 32'd0);
        check("beq1_cnt", instr_cnt, 32'd5);
        zero = 1'b0;
        tick();
        tick();
        check("beq0_state", 32'(state), 32'd8);
        check("beq0_pc_wr", 32'(pc_wr), 32'd0);
        tick();
        check("beq0_cnt", instr_cnt, 32'd6);

        // ori zero-extends, addi sign-extends
        opcode = 6'h0D;
        tick();
        tick();
        check("ori_iex_state", 32'(state), 32'd10);
        check("ori_ext_op", 32'(ext_op), 32'd0);
        check("ori_aluop", 32'(alu_op), 32'd1);
        check("ori_srcb", 32'(alu_src_b), 32'd2);
        tick();
        check("ori_iwb_state", 32'(state), 32'd11);
        check("ori_iwb_reg_wr", 32'(reg_wr), 32'd1);
        check("ori_iwb_regdst", 32'(reg_dst), 32'd0);
        tick();
        opcode = 6'h08;
        tick();
        tick();
        check("addi_ext_op", 32'(ext_op), 32'd1);
        check("addi_aluop", 32'(alu_op), 32'd2);
        tick();
        check("addi_iwb_reg_wr", 32'(reg_wr), 32'd1);
        tick();
        check("addi_cnt", instr_cnt, 32'd8);

        // illegal opcode returns after ID without counting
        opcode = 6'h3F;
        tick();
        check("ill_id_state", 32'(state), 32'd1);
        check("ill_before", 32'(illegal), 32'd0);
        tick();
        check("ill_state", 32'(state), 32'd0);
        check("ill_flag", 32'(illegal), 32'd1);
        check("ill_cnt", instr_cnt, 32'd8);

        // jump after illegal still completes; flag stays set
        opcode = 6'h02;
        tick();
        tick();
        check("j_state", 32'(state), 32'd9);
        check("j_pc_src", 32'(pc_src), 32'd2);
        check("j_pc_wr", 32'(pc_wr), 32'd1);
        tick();
        check("j_cnt", instr_cnt, 32'd9);
        check("j_illegal_sticky", 32'(illegal), 32'd1);

        // reset asserted during MRD
        opcode = 6'h23;
        tick();
        tick();
        tick();
        check("mid_mrd_state", 32'(state), 32'd3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_mem_rd", 32'(mem_rd), 32'd0);
        check("mid_rst_pc_wr", 32'(pc_wr), 32'd0);
        check("mid_rst_reg_wr", 32'(reg_wr), 32'd0);
        check("mid_rst_illegal", 32'(illegal), 32'd0);
        check("mid_rst_cnt", instr_cnt, 32'd0);
        tick();

        // unknown funct: ADD, still writes back, sets illegal
        opcode = 6'h00;
        funct  = 6'h3F;
        rst_n  = 1'b1;
        tick();
        tick();
        check("badfn_rex_state", 32'(state), 32'd6);
        check("badfn_aluop", 32'(alu_op), 32'd2);
        check("badfn_before", 32'(illegal), 32'd0);
        tick();
        check("badfn_rwb_reg_wr", 32'(reg_wr), 32'd1);
        check("badfn_illegal", 32'(illegal), 32'd1);
        tick();
        check("badfn_cnt", instr_cnt, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
